// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one floating-point unit among NREQ requesters.
// Includes a compact combinational fpu (normal numbers, truncating rounding).

module fpu #(
    parameter int NX = 8,
    parameter int NM = 23
) (
    input  logic [2:0]     op,
    input  logic [NX+NM:0] a,
    input  logic [NX+NM:0] b,
    output logic [NX+NM:0] y
);
    localparam int W    = 1 + NX + NM;
    localparam int BIAS = (1 << (NX - 1)) - 1;
    localparam int EMAX = (1 << NX) - 1;
    localparam int VW   = 2 * W;

    function automatic int msb(input logic [VW-1:0] v);
        int p;
        p = -1;
        for (int i = 0; i < VW; i++) begin
            if (v[i]) p = i;
        end
        return p;
    endfunction

    // Pack v * 2^(e0 - BIAS) (v an unnormalised integer mantissa) into a float.
    function automatic logic [W-1:0] norm(input logic s, input int e0, input logic [VW-1:0] v);
        logic [VW-1:0] t;
        int p;
        int e;
        p = msb(v);
        if (p < 0) return {s, {(W-1){1'b0}}};
        t = v << (VW - 1 - p);
        e = e0 + p;
        if (e <= 0) return {s, {(W-1){1'b0}}};
        if (e >= EMAX) return {s, {NX{1'b1}}, {NM{1'b0}}};
        return {s, e[NX-1:0], t[VW-2 -: NM]};
    endfunction

    logic          sa, sb, sl;
    int            ea, eb, el, sh;
    logic [VW-1:0] ma, mb, xl, xs, r;
    logic [W-1:0]  ia;

    always_comb begin
        sa = a[W-1];
        sb = b[W-1] ^ (op == 3'd1);
        ea = int'(a[W-2:NM]);
        eb = int'(b[W-2:NM]);
        ma = VW'({(a[W-2:NM] != '0), a[NM-1:0]});
        mb = VW'({(b[W-2:NM] != '0), b[NM-1:0]});
        sl = 1'b0;
        el = 0;
        sh = 0;
        xl = '0;
        xs = '0;
        r  = '0;
        ia = '0;
        y  = '0;
        case (op)
            3'd0, 3'd1: begin
                // Two guard bits keep the subtract path from losing the alignment bits.
                if (a[W-2:0] >= b[W-2:0]) begin
                    sl = sa;
                    el = ea;
                    xl = ma << 2;
                    xs = (mb << 2) >> (ea - eb);
                end else begin
                    sl = sb;
                    el = eb;
                    xl = mb << 2;
                    xs = (ma << 2) >> (eb - ea);
                end
                r = (sa == sb) ? xl + xs : xl - xs;
                y = norm(sl, el - (NM + 2), r);
            end
            3'd2: y = norm(sa ^ sb, ea + eb - BIAS - 2 * NM, ma * mb);
            3'd3: begin
                if (eb == 0) y = {sa ^ sb, {NX{1'b1}}, {NM{1'b0}}};
                else         y = norm(sa ^ sb, ea - eb + BIAS - (NM + 2), (ma << (NM + 2)) / mb);
            end
            3'd4: begin
                sh = ea - BIAS - NM;
                if (ea == 0)    r = '0;
                else if (sh >= 0) r = ma << sh;
                else            r = ma >> (-sh);
                y = sa ? -r[W-1:0] : r[W-1:0];
            end
            3'd5: begin
                ia = a[W-1] ? -a : a;
                r  = VW'(ia);
                y  = norm(a[W-1], BIAS, r);
            end
            default: y = '0;
        endcase
    end
endmodule

module fpu_arbiter #(
    parameter int NX      = 8,
    parameter int NM      = 23,
    parameter int NREQ    = 4,
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 12,
    parameter int LAT_CVT = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [3*NREQ-1:0]           req_op,
    input  logic [NREQ*(1+NX+NM)-1:0]   req_a,
    input  logic [NREQ*(1+NX+NM)-1:0]   req_b,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(NREQ)-1:0]     rsp_id,
    output logic [NX+NM:0]              rsp_data,
    output logic                        rsp_err
);
    localparam int W    = 1 + NX + NM;
    localparam int IW   = $clog2(NREQ);
    localparam int LM1  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
    localparam int LM2  = (LAT_DIV > LAT_CVT) ? LAT_DIV : LAT_CVT;
    localparam int LMAX = (LM1 > LM2) ? LM1 : LM2;
    localparam int CW   = $clog2(LMAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr, grant, id_reg;
    logic          grant_ok, accept;
    int            scan_idx;
    logic [2:0]    acc_op, op_reg;
    logic [W-1:0]  a_reg, b_reg, fpu_y;
    logic [CW-1:0] counter;

    function automatic logic [CW-1:0] lat_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1: return CW'(LAT_ADD);
            3'd2:       return CW'(LAT_MUL);
            3'd3:       return CW'(LAT_DIV);
            3'd4, 3'd5: return CW'(LAT_CVT);
            default:    return CW'(1);
        endcase
    endfunction

    // Scan downward so the requester nearest rr_ptr is the last (winning) assignment.
    always_comb begin
        grant    = '0;
        grant_ok = 1'b0;
        scan_idx = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            if (req_valid[scan_idx]) begin
                grant    = IW'(scan_idx);
                grant_ok = 1'b1;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = !rst && (state == IDLE) && grant_ok && (grant == IW'(gi));
        end
    endgenerate

    assign accept = |(req_valid & req_ready);
    assign acc_op = req_op[grant*3 +: 3];

    fpu #(.NX(NX), .NM(NM)) u_fpu (
        .op (op_reg),
        .a  (a_reg),
        .b  (b_reg),
        .y  (fpu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_reg    <= '0;
            op_reg    <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            counter   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_reg  <= acc_op;
                        a_reg   <= req_a[grant*W +: W];
                        b_reg   <= req_b[grant*W +: W];
                        id_reg  <= grant;
                        rr_ptr  <= (grant == IW'(NREQ - 1)) ? '0 : grant + 1'b1;
                        counter <= lat_of(acc_op);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    counter <= counter - 1'b1;
                    if (counter == CW'(1)) begin
                        rsp_valid <= 1'b1;
                        rsp_id    <= id_reg;
                        rsp_err   <= (op_reg > 3'd5);
                        rsp_data  <= (op_reg > 3'd5) ? '0 : fpu_y;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_arbiter.sv
// Directed bench for fpu_arbiter: reset, round-robin, backpressure, conversions, illegal op, reset abort.
module tb_fpu_arbiter;
    localparam int NREQ = 4;

    localparam logic [31:0] F1_5  = 32'h3FC00000;
    localparam logic [31:0] F2_25 = 32'h40100000;
    localparam logic [31:0] F3_75 = 32'h40700000;
    localparam logic [31:0] F2_0  = 32'h40000000;
    localparam logic [31:0] F3_0  = 32'h40400000;
    localparam logic [31:0] F6_0  = 32'h40C00000;
    localparam logic [31:0] F10_0 = 32'h41200000;
    localparam logic [31:0] F4_0  = 32'h40800000;
    localparam logic [31:0] F2_5  = 32'h40200000;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid, req_ready;
    logic [11:0]  req_op;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         rsp_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    fpu_arbiter #(.NX(8), .NM(23), .NREQ(NREQ), .LAT_ADD(2), .LAT_MUL(3),
                  .LAT_DIV(12), .LAT_CVT(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid[i]   = 1'b1;
        req_op[3*i+:3] = op;
        req_a[32*i+:32] = a;
        req_b[32*i+:32] = b;
    endtask

    task automatic run_op(input string tag, input int i, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp, input logic err);
        set_req(i, op, a, b);
        #1;
        check({tag, " ready"}, 32'(req_ready), 32'(1 << i));
        step();
        req_valid[i] = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            step();
            check({tag, " valid"}, 32'(rsp_valid), 32'(k == lat));
        end
        check({tag, " id"}, 32'(rsp_id), 32'(i));
        check({tag, " data"}, rsp_data, exp);
        check({tag, " err"}, 32'(rsp_err), 32'(err));
        $display("txn %s: id=%0d data=%h err=%0d", tag, rsp_id, rsp_data, rsp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check({tag, " drop"}, 32'(rsp_valid), 32'(0));
    endtask

    initial begin
        int last;
        int t;
        int seen;
        rst = 1'b1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;

        // Reset state, including req_ready held low while requests are pending.
        step();
        req_valid = 4'hF;
        step();
        check("reset ready", 32'(req_ready), 32'(0));
        check("reset valid", 32'(rsp_valid), 32'(0));
        check("reset id", 32'(rsp_id), 32'(0));
        check("reset data", rsp_data, 32'(0));
        check("reset err", 32'(rsp_err), 32'(0));
        req_valid = '0;
        rst = 1'b0;
        step();

        // Round-robin with all four requesting mul 2.0*3.0.
        for (int i = 0; i < NREQ; i++) set_req(i, 3'd2, F2_0, F3_0);
        rsp_ready = 1'b1;
        #1;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            t = 0;
            while (req_ready == '0 && t < 20) begin
                step();
                t++;
            end
            check("rr grant", 32'(req_ready), 32'(1 << (g % NREQ)));
            if (g > 0) check("rr spacing", 32'(cyc - last), 32'(5));
            last = cyc;
            step();
            if (g == 4) req_valid = '0;
            t = 0;
            while (!rsp_valid && t < 20) begin
                step();
                t++;
            end
            check("rr id", 32'(rsp_id), 32'(g % NREQ));
            check("rr data", rsp_data, F6_0);
            $display("txn rr%0d: id=%0d data=%h", g, rsp_id, rsp_data);
        end
        step();
        rsp_ready = 1'b0;

        run_op("add", 0, 3'd0, F1_5, F2_25, 2, F3_75, 1'b0);

        // Backpressure: div held for 7 cycles while req0 waits.
        set_req(1, 3'd3, F10_0, F4_0);
        #1;
        check("div ready", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid[1] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("div valid", 32'(rsp_valid), 32'(k == 12));
        end
        set_req(0, 3'd0, F1_5, F2_25);
        for (int k = 0; k < 7; k++) begin
            #1;
            check("bp data", rsp_data, F2_5);
            check("bp valid", 32'(rsp_valid), 32'(1));
            check("bp ready", 32'(req_ready), 32'(0));
            step();
        end
        $display("txn div: id=%0d data=%h err=%0d", rsp_id, rsp_data, rsp_err);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("bp drop", 32'(rsp_valid), 32'(0));
        check("bp next grant", 32'(req_ready), 32'(4'b0001));
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        check("bp add valid", 32'(rsp_valid), 32'(1));
        check("bp add data", rsp_data, F3_75);
        $display("txn bp-add: id=%0d data=%h", rsp_id, rsp_data);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;

        run_op("to_int", 1, 3'd4, 32'h449A5666, 32'h0, 1, 32'h000004D2, 1'b0);
        run_op("from_int", 2, 3'd5, 32'hFFFFFFD6, 32'h0, 1, 32'hC2280000, 1'b0);
        run_op("illegal", 2, 3'd7, F1_5, F2_25, 1, 32'h0, 1'b1);

        // Reset five cycles into a div: the op is dropped, outputs clear at once.
        set_req(1, 3'd3, F10_0, F4_0);
        #1;
        check("abort ready", 32'(req_ready), 32'(4'b0010));
        step();
        req_valid[1] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        #1;
        check("abort valid", 32'(rsp_valid), 32'(0));
        check("abort id", 32'(rsp_id), 32'(0));
        check("abort err", 32'(rsp_err), 32'(0));
        check("abort data", rsp_data, 32'(0));
        step();
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (rsp_valid) seen++;
        end
        check("abort no rsp", 32'(seen), 32'(0));
        run_op("post_rst", 3, 3'd0, F1_5, F2_25, 2, F3_75, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
